// File: rtl/crc_pkg.sv
// Shared CRC-8 definitions for the serial generator/checker pair.
// Latency: n/a (types, constants, combinational helper). Backpressure: n/a.
package crc_pkg;

    localparam int             CRC_WIDTH = 8;
    localparam logic [7:0]     CRC_TAPS  = 8'h44;
    localparam logic [7:0]     CRC_SEED  = 8'hD8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        CHECK  = 2'd2,
        REPORT = 2'd3
    } crc_state_t;

    // One serial step: feedback enters at the MSB and is folded into tapped bits.
    function automatic logic [CRC_WIDTH-1:0] lfsr_step(
        input logic [CRC_WIDTH-1:0] lfsr,
        input logic                 din,
        input logic [CRC_WIDTH-1:0] taps = CRC_TAPS
    );
        logic                 fb;
        logic [CRC_WIDTH-1:0] nxt;
        fb             = lfsr[0] ^ din;
        nxt            = '0;
        nxt[CRC_WIDTH-1] = fb;
        for (int i = 0; i < CRC_WIDTH-1; i++) begin
            nxt[i] = lfsr[i+1] ^ (taps[i] & fb);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/crc_lfsr_core.sv
// CRC LFSR register with seed load, payload step and zero-fill shift-out.
// Latency: 1 cycle per operation. Backpressure: none; holds when no control is set.
module crc_lfsr_core
    import crc_pkg::*;
#(
    parameter int               WIDTH = CRC_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = CRC_TAPS,
    parameter logic [WIDTH-1:0] SEED  = CRC_SEED
) (
    input  logic CLK,
    input  logic RST,
    input  logic load_seed,
    input  logic step,
    input  logic step_bit,
    input  logic shift_out,
    output logic lfsr_lsb
);

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;
    logic [WIDTH-1:0] step_base;

    // Stepping together with a seed load starts the next frame straight from SEED.
    assign step_base = load_seed ? SEED : lfsr_q;

    always_comb begin
        lfsr_d = lfsr_q;
        if (step) begin
            lfsr_d = lfsr_step(step_base, step_bit, TAPS);
        end else if (load_seed) begin
            lfsr_d = SEED;
        end else if (shift_out) begin
            lfsr_d = lfsr_q >> 1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_lsb = lfsr_q[0];

endmodule

// File: rtl/crc_checker.sv
// Serial CRC-8 receive checker: recompute over payload, compare trailing CRC LSB first.
// Latency: done pulses 1 cycle after the last CRC bit. Backpressure: none; qualifier-low cycles stall.
module crc_checker
    import crc_pkg::*;
#(
    parameter int               WIDTH = CRC_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = CRC_TAPS,
    parameter logic [WIDTH-1:0] SEED  = CRC_SEED
) (
    input  logic CLK,
    input  logic RST,
    input  logic Data,
    input  logic ACTIVE,
    input  logic CRC_IN,
    input  logic CRC_VALID,
    output logic busy,
    output logic done,
    output logic crc_ok,
    output logic proto_err
);

    localparam int CW = $clog2(WIDTH) + 1;

    crc_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mismatch_q, mismatch_d;
    logic          busy_q, busy_d;
    logic          crc_ok_q, crc_ok_d;
    logic          proto_err_q, proto_err_d;

    logic load_seed, step, shift_out;
    logic lfsr_lsb;
    logic bit_miss, last_bit;

    assign bit_miss = CRC_IN ^ lfsr_lsb;
    assign last_bit = (cnt_q == CW'(WIDTH-1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mismatch_d  = mismatch_q;
        busy_d      = busy_q;
        crc_ok_d    = crc_ok_q;
        proto_err_d = proto_err_q;
        load_seed   = 1'b0;
        step        = 1'b0;
        shift_out   = 1'b0;

        case (state_q)
            IDLE, REPORT: begin
                // REPORT retires the frame and then decodes inputs exactly as IDLE does.
                if (state_q == REPORT) begin
                    load_seed  = 1'b1;
                    cnt_d      = '0;
                    mismatch_d = 1'b0;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end
                if (CRC_VALID) begin
                    state_d     = REPORT;
                    crc_ok_d    = 1'b0;
                    proto_err_d = 1'b1;
                end else if (ACTIVE) begin
                    step    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = DATA;
                end
            end
            DATA, CHECK: begin
                if (ACTIVE && (CRC_VALID || state_q == CHECK)) begin
                    state_d     = REPORT;
                    crc_ok_d    = 1'b0;
                    proto_err_d = 1'b1;
                end else if (ACTIVE) begin
                    step = 1'b1;
                end else if (CRC_VALID) begin
                    shift_out  = 1'b1;
                    cnt_d      = cnt_q + CW'(1);
                    mismatch_d = mismatch_q | bit_miss;
                    if (last_bit) begin
                        state_d     = REPORT;
                        crc_ok_d    = ~(mismatch_q | bit_miss);
                        proto_err_d = 1'b0;
                    end else begin
                        state_d = CHECK;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mismatch_q  <= 1'b0;
            busy_q      <= 1'b0;
            crc_ok_q    <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mismatch_q  <= mismatch_d;
            busy_q      <= busy_d;
            crc_ok_q    <= crc_ok_d;
            proto_err_q <= proto_err_d;
        end
    end

    crc_lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_lfsr (
        .CLK       (CLK),
        .RST       (RST),
        .load_seed (load_seed),
        .step      (step),
        .step_bit  (Data),
        .shift_out (shift_out),
        .lfsr_lsb  (lfsr_lsb)
    );

    assign busy      = busy_q;
    assign done      = (state_q == REPORT);
    assign crc_ok    = crc_ok_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_crc_checker.sv
// Scoreboarded bench for crc_checker: directed frames plus randomized frames vs. a frame-level model.
module tb_crc_checker;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic Data = 1'b0;
    logic ACTIVE = 1'b0;
    logic CRC_IN = 1'b0;
    logic CRC_VALID = 1'b0;
    logic busy, done, crc_ok, proto_err;

    always #5 CLK = ~CLK;

    crc_checker dut (
        .CLK       (CLK),
        .RST       (RST),
        .Data      (Data),
        .ACTIVE    (ACTIVE),
        .CRC_IN    (CRC_IN),
        .CRC_VALID (CRC_VALID),
        .busy      (busy),
        .done      (done),
        .crc_ok    (crc_ok),
        .proto_err (proto_err)
    );

    typedef struct {
        bit ok;
        bit perr;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    bit   payload[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   pushed = 0;
    int   seen = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference CRC: shift right, inject (0x80|TAPS) whenever the feedback bit is 1.
    function automatic logic [7:0] crc_model();
        logic [7:0] r;
        r = 8'hD8;
        foreach (payload[i]) begin
            if ((r[0] ^ payload[i]) == 1'b1) r = (r >> 1) ^ (8'h80 | 8'h44);
            else                             r = r >> 1;
        end
        return r;
    endfunction

    task automatic push_exp(input bit ok, input bit perr);
        exp_t e;
        e.ok = ok; e.perr = perr; e.cyc = cyc;
        exp_q.push_back(e);
        pushed++;
    endtask

    task automatic drive(input logic a, input logic d, input logic v, input logic c);
        ACTIVE = a; Data = d; CRC_VALID = v; CRC_IN = c;
        @(posedge CLK);
        #1;
    endtask

    task automatic release_inputs();
        ACTIVE = 1'b0; Data = 1'b0; CRC_VALID = 1'b0; CRC_IN = 1'b0;
    endtask

    task automatic idle(input int n);
        release_inputs();
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // err_mode: 0 clean, 1 ACTIVE before CRC bit stall_at, 2 ACTIVE+CRC_VALID after payload.
    task automatic send_frame(input logic [7:0] crc, input int stall_at, input int stall_len,
                              input int err_mode, input int gap_pct);
        logic [7:0] good;
        good = crc_model();
        foreach (payload[i]) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) drive(1'b0, 1'b0, 1'b0, 1'b0);
            drive(1'b1, payload[i], 1'b0, 1'b0);
            if (i == 0) chk("busy_after_first_bit", busy, 1);
        end
        if (err_mode == 2) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0);
            push_exp(1'b0, 1'b1);
            release_inputs();
            return;
        end
        for (int j = 0; j < 8; j++) begin
            if (j == stall_at) begin
                repeat (stall_len) drive(1'b0, 1'b0, 1'b0, 1'b0);
                if (err_mode == 1) begin
                    drive(1'b1, 1'b1, 1'b0, 1'b0);
                    push_exp(1'b0, 1'b1);
                    release_inputs();
                    return;
                end
            end
            drive(1'b0, 1'b0, 1'b1, crc[j]);
        end
        push_exp(crc == good, 1'b0);
        release_inputs();
    endtask

    // Monitor: every done pulse must match the oldest expected verdict and cycle.
    always @(negedge CLK) begin
        if (!RST && done) begin
            exp_t e;
            seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("crc_ok", crc_ok, e.ok);
                chk("proto_err", proto_err, e.perr);
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] crc;
        int         n;
        int         sa;
        int         mode;

        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_crc_ok", crc_ok, 0);
        chk("rst_proto_err", proto_err, 0);
        idle(2);

        payload = '{1'b1};      send_frame(8'hA8, 8, 0, 0, 0); idle(2);
        payload = '{1'b0};      send_frame(8'h6C, 8, 0, 0, 0); idle(2);
        payload = '{1'b0};      send_frame(8'hEC, 8, 0, 0, 0); idle(2);
        payload = '{1'b1, 1'b0}; send_frame(8'h54, 4, 3, 0, 0); idle(2);

        payload = '{1'b1};      send_frame(8'hA8, 8, 0, 0, 0);
        payload = '{1'b0};      send_frame(8'h6C, 8, 0, 0, 0); idle(2);

        payload = '{1'b1};      send_frame(8'hA8, 3, 0, 1, 0); idle(2);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        push_exp(1'b0, 1'b1);
        idle(2);
        payload = '{1'b1, 1'b1}; send_frame(8'h00, 8, 0, 2, 0); idle(2);

        // Reset mid-CHECK: no verdict, busy drops, next frame is unaffected.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        for (int j = 0; j < 4; j++) drive(1'b0, 1'b0, 1'b1, j[0]);
        release_inputs();
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        chk("busy_after_rst", busy, 0);
        chk("done_after_rst", done, 0);
        idle(2);
        payload = '{1'b1};      send_frame(8'hA8, 8, 0, 0, 0); idle(2);

        for (int f = 0; f < 60; f++) begin
            payload.delete();
            n = $urandom_range(24, 1);
            for (int i = 0; i < n; i++) payload.push_back(1'($urandom_range(1)));
            crc = crc_model();
            if ($urandom_range(1) == 1) crc[$urandom_range(7)] ^= 1'b1;
            sa   = $urandom_range(7, 1);
            mode = ($urandom_range(9) == 0) ? int'($urandom_range(2, 1)) : 0;
            send_frame(crc, sa, $urandom_range(3), mode, 20);
            if ($urandom_range(3) != 0) idle($urandom_range(3, 1));
        end

        idle(4);
        chk("queue_drained", exp_q.size(), 0);
        chk("verdict_count", seen, pushed);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crc_checker.md
Name: crc_checker

Overview:
- Receive-side counterpart of the team's serial CRC-8 generator.
- Recomputes the CRC over a serial payload using the same polynomial and seed, then compares it bit-by-bit against the 8 CRC bits that follow, LSB first.
- Reports pass/fail with a one-cycle done pulse.
- Sits at the link receiver, directly after the serial deserialising front end.

Parameters:
- WIDTH, 8, CRC/LFSR width in bits.
- TAPS, 8'h44, XOR tap mask; bit i set means LFSR[i] takes LFSR[i+1]^feedback.
- SEED, 8'hD8, LFSR value loaded at reset and at the start of each frame.

Ports:
- CLK  input  1  clock; all logic on the rising edge.
- RST  input  1  synchronous, active-high reset.
- Data  input  1  serial payload bit; sampled while ACTIVE=1.
- ACTIVE  input  1  payload phase qualifier.
- CRC_IN  input  1  serial received CRC bit, LSB first; sampled while CRC_VALID=1.
- CRC_VALID  input  1  CRC phase qualifier; high for exactly WIDTH cycles per frame.
- busy  output  1  high from the first ACTIVE cycle until done.
- done  output  1  one-cycle pulse when a frame verdict is available.
- crc_ok  output  1  verdict; meaningful when done=1, held until the next done.
- proto_err  output  1  verdict qualifier; the frame broke the sequencing rules. Held with crc_ok.

Behaviour:
- Reset: one clock only; RST=1 at a rising edge. Values: LFSR=SEED, cnt=0, mismatch=0, state=IDLE, busy=0, done=0, crc_ok=0, proto_err=0. Reset mid-frame abandons the frame with no done pulse.
- Feedback: fb = LFSR[0]^Data. Update: LFSR[WIDTH-1]<=fb; for i<WIDTH-1, LFSR[i]<=LFSR[i+1]^(TAPS[i]&fb). This is bit-identical to the generator.
- State IDLE:
  - ACTIVE=1: update LFSR with Data, go to DATA, busy<=1.
  - CRC_VALID=1 with no prior payload: protocol error (see Errors).
- State DATA:
  - ACTIVE=1: update LFSR.
  - ACTIVE=0 and CRC_VALID=0: gap cycles allowed; LFSR holds.
  - CRC_VALID=1: enter CHECK and process this bit as check bit 0 in the same cycle.
- State CHECK, each CRC_VALID=1 cycle:
  - mismatch <= mismatch | (CRC_IN ^ LFSR[0]).
  - LFSR <= LFSR>>1, zero-filled.
  - cnt increments.
  - On the cycle cnt==WIDTH-1 is processed, go to REPORT.
- CRC_VALID=0 inside CHECK before WIDTH bits: stall; no shift, no count.
- State REPORT, one cycle:
  - done=1, crc_ok=~mismatch_final, proto_err as recorded.
  - Reload LFSR=SEED, clear cnt and mismatch, busy<=0, return to IDLE.
  - mismatch_final includes the last bit's compare.
- Latency: done asserts on the cycle after the last CRC bit is sampled.
- Back-to-back frames: ACTIVE may rise in the REPORT cycle. That bit is the first payload bit of the next frame, applied to SEED; the next state is DATA.
- Errors (proto_err=1, crc_ok=0, frame ends via REPORT):
  - ACTIVE and CRC_VALID both high in the same cycle.
  - ACTIVE=1 while in CHECK.
  - CRC_VALID=1 in IDLE.
  - Each case triggers an immediate transition to REPORT.
- Widths: cnt is clog2(WIDTH)+1 bits; no wrap inside a frame.

Decomposition:
- Shared package crc_pkg holds:
  - CRC_WIDTH=8, CRC_TAPS=8'h44, CRC_SEED=8'hD8;
  - the state enum {IDLE, DATA, CHECK, REPORT};
  - function lfsr_step(lfsr, bit) returning the next LFSR.
- The generator should migrate to the same package.
- Sub-module crc_lfsr_core: LFSR register with load_seed, step(bit) and shift_out controls. The FSM, compare and verdict logic stay in crc_checker.

Test Plan:
- Single payload bit Data=1 then CRC_IN LSB-first 0,0,0,1,0,1,0,1 (0xA8) -> done one cycle after the 8th bit, crc_ok=1, proto_err=0.
- Single payload bit Data=0 then CRC 0x6C (0,0,1,1,0,1,1,0) -> crc_ok=1. Repeat with bit 7 flipped (0xEC) -> crc_ok=0.
- Payload 1,0 then CRC 0x54 with a 3-cycle CRC_VALID=0 stall after bit 4 -> crc_ok=1; done exactly 1 cycle after the last bit.
- Two back-to-back frames (1->0xA8, then 0->0x6C) with ACTIVE in the REPORT cycle -> two done pulses, both crc_ok=1.
- Protocol errors:
  - ACTIVE=1 during CHECK -> done next cycle, proto_err=1, crc_ok=0.
  - CRC_VALID in IDLE -> same response.
- RST=1 after 4 CRC bits -> no done; busy=0 next cycle; a following frame 1->0xA8 passes.
